// File: rtl/l2_state_writer_pkg.sv
// Shared types for the L2 tag/state write path: op encoding, INVALID state, FIFO entry layout.
// Entry field widths follow the build widths below; the top-level parameters default to them.
package l2_state_writer_pkg;

    localparam int unsigned PKG_L2_WAYS    = 8;
    localparam int unsigned PKG_SET_BITS   = 8;
    localparam int unsigned PKG_TAG_BITS   = 20;
    localparam int unsigned PKG_STATE_BITS = 3;
    localparam int unsigned PKG_QDEPTH     = 2;
    localparam int unsigned PKG_WAY_BITS   = $clog2(PKG_L2_WAYS);

    typedef enum logic [1:0] {
        L2_FILL       = 2'd0,
        L2_SET_STATE  = 2'd1,
        L2_INVALIDATE = 2'd2,
        L2_RSVD       = 2'd3
    } l2_wr_op_t;

    localparam logic [PKG_STATE_BITS-1:0] INVALID = '0;

    typedef struct packed {
        l2_wr_op_t                 op;
        logic [PKG_SET_BITS-1:0]   set_idx;
        logic [PKG_WAY_BITS-1:0]   way;
        logic [PKG_TAG_BITS-1:0]   tag;
        logic [PKG_STATE_BITS-1:0] state;
    } l2_wr_entry_t;

endpackage

// File: rtl/l2_state_writer_if.sv
// Request channel from the L2 controller and write port toward the tag/state array arbiter.
// master: controller/arbiter side; slave: l2_state_writer.
interface l2_state_writer_if #(
    parameter int unsigned L2_WAYS    = 8,
    parameter int unsigned SET_BITS   = 8,
    parameter int unsigned TAG_BITS   = 20,
    parameter int unsigned STATE_BITS = 3
);
    localparam int unsigned WAY_BITS = $clog2(L2_WAYS);

    logic                  req_valid;
    logic                  req_ready;
    logic [1:0]            req_op;
    logic [SET_BITS-1:0]   req_set;
    logic [WAY_BITS-1:0]   req_way;
    logic                  req_use_evict;
    logic [TAG_BITS-1:0]   req_tag;
    logic [STATE_BITS-1:0] req_state;

    logic                  wr_en;
    logic                  wr_gnt;
    logic [SET_BITS-1:0]   wr_set;
    logic [WAY_BITS-1:0]   wr_way;
    logic                  wr_tag_en;
    logic [TAG_BITS-1:0]   wr_tag;
    logic [STATE_BITS-1:0] wr_state;

    logic [WAY_BITS-1:0]   evict_way;
    logic                  pending;

    modport master (
        output req_valid, req_op, req_set, req_way, req_use_evict, req_tag, req_state, wr_gnt,
        input  req_ready, wr_en, wr_set, wr_way, wr_tag_en, wr_tag, wr_state, evict_way, pending
    );

    modport slave (
        input  req_valid, req_op, req_set, req_way, req_use_evict, req_tag, req_state, wr_gnt,
        output req_ready, wr_en, wr_set, wr_way, wr_tag_en, wr_tag, wr_state, evict_way, pending
    );

endinterface

// File: rtl/l2_wr_fifo.sv
// Generic registered FIFO with wrap-bit pointers, head/tail read-out and in-place tail update.
module l2_wr_fifo #(
    parameter int unsigned DW    = 8,
    parameter int unsigned DEPTH = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    input  logic          upd,
    input  logic [DW-1:0] upd_data,
    output logic [DW-1:0] head_data,
    output logic [DW-1:0] tail_data,
    output logic          full,
    output logic          empty,
    output logic          single
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [PW-1:0] head_q;
    logic [PW-1:0] tail_q;
    logic [PW-1:0] last_ptr;
    logic [DW-1:0] mem_q [DEPTH];

    assign last_ptr  = tail_q - PW'(1);
    assign empty     = (head_q == tail_q);
    assign full      = (head_q[AW] != tail_q[AW]) && (head_q[AW-1:0] == tail_q[AW-1:0]);
    assign single    = ((tail_q - head_q) == PW'(1));
    assign head_data = mem_q[head_q[AW-1:0]];
    assign tail_data = mem_q[last_ptr[AW-1:0]];

    // Pointer advance; overflow/underflow requests are ignored.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q <= '0;
            tail_q <= '0;
        end else begin
            if (push && !full) begin
                tail_q <= tail_q + PW'(1);
            end
            if (pop && !empty) begin
                head_q <= head_q + PW'(1);
            end
        end
    end

    // Storage: new entry at the tail slot, or rewrite of the newest entry.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (push && !full) begin
            mem_q[tail_q[AW-1:0]] <= push_data;
        end else if (upd && !empty) begin
            mem_q[last_ptr[AW-1:0]] <= upd_data;
        end
    end

endmodule

// File: rtl/l2_state_writer.sv
// L2 tag/state write-side: request decode, way resolution, eviction pointer, optional coalescing,
// and the queued write port to the tag/state arrays.
// Optional feature macro: L2_WR_COALESCE_EN (merge state updates into a matching tail entry).
module l2_state_writer
    import l2_state_writer_pkg::*;
#(
    parameter int unsigned L2_WAYS    = PKG_L2_WAYS,
    parameter int unsigned SET_BITS   = PKG_SET_BITS,
    parameter int unsigned TAG_BITS   = PKG_TAG_BITS,
    parameter int unsigned STATE_BITS = PKG_STATE_BITS,
    parameter int unsigned QDEPTH     = PKG_QDEPTH
) (
    input  logic             clk,
    input  logic             rst,
    l2_state_writer_if.slave bus
);
    localparam int unsigned WAY_BITS = $clog2(L2_WAYS);
    localparam int unsigned ENTRY_W  = $bits(l2_wr_entry_t);
`ifdef L2_WR_COALESCE_EN
    localparam bit COALESCE_EN = 1'b1;
`else
    localparam bit COALESCE_EN = 1'b0;
`endif

    l2_wr_op_t           op_c;
    l2_wr_entry_t        enq_e;
    l2_wr_entry_t        upd_e;
    l2_wr_entry_t        head_e;
    l2_wr_entry_t        tail_e;
    logic [WAY_BITS-1:0] evict_q;
    logic                full;
    logic                empty;
    logic                single;
    logic                fill_evict_c;
    logic                tail_match_c;
    logic                coalesce_hit_c;
    logic                accept_c;
    logic                push_c;
    logic                upd_c;
    logic                pop_c;

    assign op_c         = l2_wr_op_t'(bus.req_op);
    assign fill_evict_c = (op_c == L2_FILL) && bus.req_use_evict;

    // Build the entry as it will be queued: resolved way, tag for fills, INVALID for invalidates.
    always_comb begin
        enq_e         = '0;
        enq_e.op      = op_c;
        enq_e.set_idx = PKG_SET_BITS'(bus.req_set);
        enq_e.way     = fill_evict_c ? PKG_WAY_BITS'(evict_q) : PKG_WAY_BITS'(bus.req_way);
        enq_e.tag     = (op_c == L2_FILL) ? PKG_TAG_BITS'(bus.req_tag) : '0;
        enq_e.state   = (op_c == L2_INVALIDATE) ? INVALID : PKG_STATE_BITS'(bus.req_state);
    end

    // Merged tail entry: a fill keeps its op and tag, otherwise the newer op wins.
    always_comb begin
        upd_e       = tail_e;
        upd_e.state = enq_e.state;
        if (tail_e.op != L2_FILL) begin
            upd_e.op = enq_e.op;
        end
    end

    // State-only request hitting the newest entry, unless that entry is leaving this cycle.
    always_comb begin
        tail_match_c = ((op_c == L2_SET_STATE) || (op_c == L2_INVALIDATE)) &&
                       !empty &&
                       (tail_e.set_idx == enq_e.set_idx) &&
                       (tail_e.way == enq_e.way) &&
                       !(single && pop_c);
    end

    assign coalesce_hit_c = COALESCE_EN && tail_match_c;
    assign accept_c       = bus.req_valid && bus.req_ready;
    assign push_c         = accept_c && (op_c != L2_RSVD) && !coalesce_hit_c;
    assign upd_c          = accept_c && coalesce_hit_c;
    assign pop_c          = !empty && bus.wr_gnt;

    // Round-robin victim pointer, advanced by each accepted evict-fill.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            evict_q <= '0;
        end else if (accept_c && fill_evict_c) begin
            evict_q <= evict_q + WAY_BITS'(1);
        end
    end

    l2_wr_fifo #(
        .DW    (ENTRY_W),
        .DEPTH (QDEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_c),
        .push_data (enq_e),
        .pop       (pop_c),
        .upd       (upd_c),
        .upd_data  (upd_e),
        .head_data (head_e),
        .tail_data (tail_e),
        .full      (full),
        .empty     (empty),
        .single    (single)
    );

    assign bus.req_ready = !full || coalesce_hit_c;
    assign bus.wr_en     = !empty;
    assign bus.wr_tag_en = !empty && (head_e.op == L2_FILL);
    assign bus.wr_set    = SET_BITS'(head_e.set_idx);
    assign bus.wr_way    = WAY_BITS'(head_e.way);
    assign bus.wr_tag    = TAG_BITS'(head_e.tag);
    assign bus.wr_state  = STATE_BITS'(head_e.state);
    assign bus.evict_way = evict_q;
    assign bus.pending   = !empty;

endmodule
